// File: rtl/div_pkg.sv
// Shared types and constants for the 16/8 sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam int unsigned DIV_AW = 16;
  localparam int unsigned DIV_BW = 8;

  // Iteration counts for the exact and truncated (A[15:4] only) modes.
  localparam int unsigned DIV_ITER_EXACT = 16;
  localparam int unsigned DIV_ITER_TRUNC = 12;

  // Wide enough to hold the largest iteration index.
  localparam int unsigned DIV_CNT_W = 5;

  // Partial remainder carries one guard bit above the divisor width.
  localparam int unsigned DIV_RW = DIV_BW + 1;

endpackage

// File: rtl/div_step.sv
// One combinational radix-2 restoring division step.
module div_step
  import div_pkg::*;
(
  input  logic [DIV_RW-1:0] rem_in,
  input  logic              a_bit,
  input  logic [DIV_BW-1:0] b,
  output logic [DIV_RW-1:0] rem_out,
  output logic              q_bit
);

  logic [DIV_RW:0]   shifted;
  logic [DIV_RW-1:0] diff;
  logic              fits;

  // Shift in the next dividend bit, trial-subtract B, restore on borrow.
  always_comb begin
    shifted = {rem_in, a_bit};
    fits    = (shifted >= {2'b00, b});
    // When the subtraction fits, the true difference is below B, so 9 bits suffice.
    diff    = shifted[DIV_RW-1:0] - {1'b0, b};
    rem_out = fits ? diff : shifted[DIV_RW-1:0];
    q_bit   = fits;
  end

endmodule

// File: rtl/div_16x8_seq.sv
// Sequential 16/8 unsigned restoring divider behind a valid/ready handshake.
// One operation in flight; divide-by-zero returns Q=FFFF, R=A[7:0], dz=1.
// Optional macro DIV_TRUNC_EN: divide A[15:4] only (12 iterations), Q low nibble
// and R forced to zero.
module div_16x8_seq
  import div_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DIV_AW-1:0] A,
  input  logic [DIV_BW-1:0] B,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DIV_AW-1:0] Q,
  output logic [DIV_BW-1:0] R,
  output logic              dz
);

`ifdef DIV_TRUNC_EN
  localparam int unsigned NumIter = DIV_ITER_TRUNC;
`else
  localparam int unsigned NumIter = DIV_ITER_EXACT;
`endif

  localparam logic [DIV_CNT_W-1:0] LastIdx = DIV_CNT_W'(NumIter - 1);

  div_state_e           state_q;
  logic [DIV_AW-1:0]    a_sh_q;   // dividend bits shift out the top, quotient bits in the bottom
  logic [DIV_BW-1:0]    b_q;
  logic [DIV_RW-1:0]    rem_q;
  logic [DIV_CNT_W-1:0] cnt_q;

  logic [DIV_RW-1:0]    rem_nx;
  logic                 q_bit;
  logic [DIV_AW-1:0]    a_sh_nx;
  logic                 last_iter;
  logic [DIV_AW-1:0]    q_final;
  logic [DIV_BW-1:0]    r_final;

  // Single shared step, fed from the registered state every BUSY cycle.
  div_step u_step (
    .rem_in  (rem_q),
    .a_bit   (a_sh_q[DIV_AW-1]),
    .b       (b_q),
    .rem_out (rem_nx),
    .q_bit   (q_bit)
  );

  // Next shift-register value and the result presented after the final step.
  always_comb begin
    a_sh_nx   = {a_sh_q[DIV_AW-2:0], q_bit};
    last_iter = (cnt_q == LastIdx);
`ifdef DIV_TRUNC_EN
    // After 12 steps the low 12 bits hold floor(A[15:4]/B).
    q_final   = {a_sh_nx[DIV_AW-5:0], 4'b0000};
    r_final   = '0;
`else
    q_final   = a_sh_nx;
    r_final   = rem_nx[DIV_BW-1:0];
`endif
  end

  // Control FSM, datapath registers and registered handshake/result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_sh_q    <= '0;
      b_q       <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      Q         <= '0;
      R         <= '0;
      dz        <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_sh_q   <= A;
            b_q      <= B;
            rem_q    <= '0;
            cnt_q    <= '0;
            in_ready <= 1'b0;
            if (B == '0) begin
              Q         <= '1;
              R         <= A[DIV_BW-1:0];
              dz        <= 1'b1;
              out_valid <= 1'b1;
              state_q   <= DONE;
            end else begin
              dz        <= 1'b0;
              state_q   <= BUSY;
            end
          end
        end

        BUSY: begin
          a_sh_q <= a_sh_nx;
          rem_q  <= rem_nx;
          if (last_iter) begin
            Q         <= q_final;
            R         <= r_final;
            out_valid <= 1'b1;
            state_q   <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        DONE: begin
          // Result stays frozen until the consumer takes it.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_q   <= IDLE;
          end
        end

        default: begin
          state_q   <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_16x8_seq.sv
// Directed bench for div_16x8_seq: vector table plus back-pressure and reset sequences.
module tb_div_16x8_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] A;
  logic [7:0]  B;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] Q;
  logic [7:0]  R;
  logic        dz;

  int n_cmp;
  int n_bad;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  b;
    logic [15:0] q;
    logic [7:0]  r;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t vecs[5];

  div_16x8_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Q         (Q),
    .R         (R),
    .dz        (dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Issue one operation and wait (bounded) for out_valid; lat counts edges after accept.
  task automatic do_op(input logic [15:0] a, input logic [7:0] b,
                       output logic [15:0] q, output logic [7:0] r,
                       output logic d, output int lat);
    @(negedge clk);
    chk("in_ready_idle", {31'b0, in_ready}, 32'd1);
    A = a;
    B = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("in_ready_after_accept", {31'b0, in_ready}, 32'd0);
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid) break;
    end
    q = Q;
    r = R;
    d = dz;
  endtask

  task automatic handoff();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("out_valid_after_handoff", {31'b0, out_valid}, 32'd0);
    chk("in_ready_after_handoff", {31'b0, in_ready}, 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
    chk({tag, "_out_valid"}, {31'b0, out_valid}, 32'd0);
    chk({tag, "_Q"}, {16'b0, Q}, 32'd0);
    chk({tag, "_R"}, {24'b0, R}, 32'd0);
    chk({tag, "_dz"}, {31'b0, dz}, 32'd0);
  endtask

  initial begin
    logic [15:0] q;
    logic [7:0]  r;
    logic        d;
    int          lat;
    logic [15:0] q_hold;
    logic [7:0]  r_hold;

    n_cmp = 0;
    n_bad = 0;

`ifdef DIV_TRUNC_EN
    vecs[0] = '{a: 16'd1000,  b: 8'd7,   q: 16'd128,   r: 8'd0,    dz: 1'b0, lat: 12};
    vecs[1] = '{a: 16'hFFFF,  b: 8'hFF,  q: 16'd256,   r: 8'd0,    dz: 1'b0, lat: 12};
    vecs[2] = '{a: 16'd5,     b: 8'd10,  q: 16'd0,     r: 8'd0,    dz: 1'b0, lat: 12};
    vecs[3] = '{a: 16'h1234,  b: 8'd0,   q: 16'hFFFF,  r: 8'h34,   dz: 1'b1, lat: 1};
    vecs[4] = '{a: 16'd50000, b: 8'd3,   q: 16'd16656, r: 8'd0,    dz: 1'b0, lat: 12};
`else
    vecs[0] = '{a: 16'd1000,  b: 8'd7,   q: 16'd142,   r: 8'd6,    dz: 1'b0, lat: 16};
    vecs[1] = '{a: 16'hFFFF,  b: 8'hFF,  q: 16'd257,   r: 8'd0,    dz: 1'b0, lat: 16};
    vecs[2] = '{a: 16'd5,     b: 8'd10,  q: 16'd0,     r: 8'd5,    dz: 1'b0, lat: 16};
    vecs[3] = '{a: 16'h1234,  b: 8'd0,   q: 16'hFFFF,  r: 8'h34,   dz: 1'b1, lat: 1};
    vecs[4] = '{a: 16'd50000, b: 8'd3,   q: 16'd16666, r: 8'd2,    dz: 1'b0, lat: 16};
`endif

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    A         = '0;
    B         = '0;
    #12;
    chk_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      do_op(vecs[i].a, vecs[i].b, q, r, d, lat);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_Q", i), {16'b0, q}, {16'b0, vecs[i].q});
      chk($sformatf("v%0d_R", i), {24'b0, r}, {24'b0, vecs[i].r});
      chk($sformatf("v%0d_dz", i), {31'b0, d}, {31'b0, vecs[i].dz});
      handoff();
    end

    // dz must clear once a nonzero-divisor operation is accepted after a divide-by-zero.
    do_op(16'd9, 8'd0, q, r, d, lat);
    handoff();
    do_op(16'd9, 8'd3, q, r, d, lat);
    chk("dz_cleared", {31'b0, d}, 32'd0);
    handoff();

    // Back-pressure: result frozen for 5 stalled cycles, second request ignored.
    do_op(16'd1000, 8'd7, q, r, d, lat);
    q_hold = q;
    r_hold = r;
    @(negedge clk);
    A = 16'd77;
    B = 8'd2;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bp%0d_out_valid", k), {31'b0, out_valid}, 32'd1);
      chk($sformatf("bp%0d_in_ready", k), {31'b0, in_ready}, 32'd0);
      chk($sformatf("bp%0d_Q", k), {16'b0, Q}, {16'b0, q_hold});
      chk($sformatf("bp%0d_R", k), {24'b0, R}, {24'b0, r_hold});
    end
    in_valid = 1'b0;
    handoff();
    @(posedge clk);
    #1;
    chk("bp_not_accepted_valid", {31'b0, out_valid}, 32'd0);
    chk("bp_not_accepted_ready", {31'b0, in_ready}, 32'd1);
    chk("bp_Q_kept", {16'b0, Q}, {16'b0, q_hold});

    // Reset 4 cycles after accept aborts the operation with no result.
    @(negedge clk);
    A = 16'd1000;
    B = 8'd7;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("midreset_no_result", {31'b0, out_valid}, 32'd0);

    do_op(16'd100, 8'd9, q, r, d, lat);
`ifdef DIV_TRUNC_EN
    chk("post_reset_Q", {16'b0, q}, 32'd0);
    chk("post_reset_R", {24'b0, r}, 32'd0);
    chk("post_reset_latency", lat, 32'd12);
`else
    chk("post_reset_Q", {16'b0, q}, 32'd11);
    chk("post_reset_R", {24'b0, r}, 32'd1);
    chk("post_reset_latency", lat, 32'd16);
`endif
    handoff();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
